// File: rtl/ofifo_pkg.sv
// ofifo_pkg: shared widths and defaults for the multi-lane output FIFO
package ofifo_pkg;
    localparam int COL_DEF    = 8;
    localparam int BW_DEF     = 16;
    localparam int DEPTH_DEF  = 64;
    localparam int AF_LVL_DEF = 56;
    typedef int unsigned lane_cnt_t;
    function automatic int ptr_w(input int d);
        return (d > 1) ? $clog2(d) : 1;
    endfunction
    function automatic int cnt_w(input int d);
        return ptr_w(d) + 1;
    endfunction
endpackage

// File: rtl/ofifo_lane.sv
// ofifo_lane: one lane's circular buffer, pointers, occupancy counter and flags
module ofifo_lane
    import ofifo_pkg::*;
#(
    parameter int bw     = BW_DEF,
    parameter int depth  = DEPTH_DEF,
    parameter int af_lvl = AF_LVL_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr,
    input  logic [bw-1:0] din,
    input  logic          pop,
    output logic [bw-1:0] head,
    output logic          empty,
    output logic          full,
    output logic          afull
);
    localparam int PW = ptr_w(depth);
    localparam int CW = cnt_w(depth);
    logic [bw-1:0] mem [depth];
    logic [PW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    logic          push;
    // a full lane still accepts a write when the row read frees a slot on the same edge
    assign push  = wr & (~full | pop);
    assign head  = mem[rp];
    assign empty = cnt == '0;
    assign full  = cnt == CW'(depth);
    assign afull = cnt >= CW'(af_lvl);
    always_ff @(posedge clk) begin
        if (reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= din;
    end
endmodule

// File: rtl/ofifo_multi.sv
// ofifo_multi: col independently written lanes released row-wise with a registered read port
// Optional sticky o_ovf/o_udf error flags when OFIFO_MULTI_ERR_EN is defined.
module ofifo_multi
    import ofifo_pkg::*;
#(
    parameter lane_cnt_t col    = COL_DEF,
    parameter int        bw     = BW_DEF,
    parameter int        depth  = DEPTH_DEF,
    parameter int        af_lvl = AF_LVL_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [col-1:0]    wr,
    input  logic [col*bw-1:0] in,
    input  logic              rd,
    output logic [col*bw-1:0] out,
    output logic              out_vld,
    output logic              o_valid,
    output logic              o_full,
    output logic              o_ready,
    output logic              o_afull
`ifdef OFIFO_MULTI_ERR_EN
    ,
    output logic              o_ovf,
    output logic              o_udf
`endif
);
    logic [col-1:0]    empty, full, afull;
    logic [col*bw-1:0] head_row;
    logic              acc;
    assign o_valid = ~|empty;
    assign o_full  = |full;
    assign o_ready = ~o_full;
    assign o_afull = |afull;
    assign acc     = rd & o_valid;
    for (genvar i = 0; i < col; i++) begin : g_lane
        ofifo_lane #(.bw(bw), .depth(depth), .af_lvl(af_lvl)) u_lane (
            .clk(clk),
            .reset(reset),
            .wr(wr[i]),
            .din(in[i*bw +: bw]),
            .pop(acc),
            .head(head_row[i*bw +: bw]),
            .empty(empty[i]),
            .full(full[i]),
            .afull(afull[i])
        );
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            out     <= '0;
            out_vld <= 1'b0;
        end else begin
            if (acc) out <= head_row;
            out_vld <= acc;
        end
    end
`ifdef OFIFO_MULTI_ERR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            o_ovf <= 1'b0;
            o_udf <= 1'b0;
        end else begin
            o_ovf <= o_ovf | (|(wr & full & ~{col{acc}}));
            o_udf <= o_udf | (rd & ~o_valid);
        end
    end
`endif
endmodule

// File: tb/tb_ofifo_multi.sv
// tb_ofifo_multi: table vectors, directed corner sequences and random traffic against a queue model
module tb_ofifo_multi;
    logic         clk = 0;
    logic         reset = 1;
    logic [7:0]   wr = '0;
    logic [127:0] in = '0;
    logic         rd = 0;
    logic [127:0] out;
    logic         out_vld, o_valid, o_full, o_ready, o_afull;
`ifdef OFIFO_MULTI_ERR_EN
    logic         o_ovf, o_udf;
    bit           e_ovf, e_udf;
`endif
    int errors = 0;
    int checks = 0;
    logic [15:0]  q [8][$];
    logic [127:0] e_out = '0;
    bit           e_vld = 0;

    always #5 clk = ~clk;

    ofifo_multi dut (
        .clk(clk), .reset(reset), .wr(wr), .in(in), .rd(rd),
        .out(out), .out_vld(out_vld), .o_valid(o_valid), .o_full(o_full),
        .o_ready(o_ready), .o_afull(o_afull)
`ifdef OFIFO_MULTI_ERR_EN
        , .o_ovf(o_ovf), .o_udf(o_udf)
`endif
    );

    typedef struct {
        bit         rst;
        logic [7:0] w;
        bit         r;
        bit         valid;
        bit         vld;
    } vec_t;

    task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", n, a, e);
        end
    endtask

    function automatic bit m_valid();
        for (int i = 0; i < 8; i++) if (q[i].size() == 0) return 0;
        return 1;
    endfunction

    function automatic bit m_full();
        for (int i = 0; i < 8; i++) if (q[i].size() == 64) return 1;
        return 0;
    endfunction

    function automatic bit m_afull();
        for (int i = 0; i < 8; i++) if (q[i].size() >= 56) return 1;
        return 0;
    endfunction

    task automatic step(input bit r, input logic [7:0] w, input logic [127:0] d, input bit rr);
        bit v, a, f;
        @(negedge clk);
        reset = r; wr = w; in = d; rd = rr;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 8; i++) q[i].delete();
            e_out = '0;
            e_vld = 0;
`ifdef OFIFO_MULTI_ERR_EN
            e_ovf = 0; e_udf = 0;
`endif
        end else begin
            v = m_valid();
            a = rr && v;
            e_vld = a;
            for (int i = 0; i < 8; i++) begin
                f = q[i].size() == 64;
                if (a) e_out[i*16 +: 16] = q[i].pop_front();
                if (w[i] && (!f || a)) q[i].push_back(d[i*16 +: 16]);
`ifdef OFIFO_MULTI_ERR_EN
                if (w[i] && f && !a) e_ovf = 1;
`endif
            end
`ifdef OFIFO_MULTI_ERR_EN
            if (rr && !v) e_udf = 1;
`endif
        end
        #1;
        chk("out", out, e_out);
        chk("out_vld", 128'(out_vld), 128'(e_vld));
        chk("o_valid", 128'(o_valid), 128'(m_valid()));
        chk("o_full", 128'(o_full), 128'(m_full()));
        chk("o_ready", 128'(o_ready), 128'(!m_full()));
        chk("o_afull", 128'(o_afull), 128'(m_afull()));
`ifdef OFIFO_MULTI_ERR_EN
        chk("o_ovf", 128'(o_ovf), 128'(e_ovf));
        chk("o_udf", 128'(o_udf), 128'(e_udf));
`endif
    endtask

    function automatic logic [127:0] rnd_row();
        logic [127:0] x;
        for (int i = 0; i < 4; i++) x[i*32 +: 32] = $urandom;
        return x;
    endfunction

    initial begin
        vec_t tbl [7];
        logic [127:0] row_a;
        for (int i = 0; i < 8; i++) row_a[i*16 +: 16] = 16'h0A00 | 16'(i);
        tbl[0] = '{1, 8'h00, 0, 0, 0};
        tbl[1] = '{0, 8'h7F, 0, 0, 0};
        tbl[2] = '{0, 8'h00, 1, 0, 0};
        tbl[3] = '{1, 8'h00, 0, 0, 0};
        tbl[4] = '{0, 8'hFF, 0, 1, 0};
        tbl[5] = '{0, 8'h00, 1, 0, 1};
        tbl[6] = '{0, 8'h00, 0, 0, 0};
        step(1, 0, 0, 0);
        chk("rst_out", out, '0);
        chk("rst_ready", 128'(o_ready), 128'(1));
        for (int k = 0; k < 7; k++) begin
            step(tbl[k].rst, tbl[k].w, row_a, tbl[k].r);
            chk("tbl_valid", 128'(o_valid), 128'(tbl[k].valid));
            chk("tbl_vld", 128'(out_vld), 128'(tbl[k].vld));
            if (tbl[k].vld) chk("tbl_out", out, row_a);
`ifdef OFIFO_MULTI_ERR_EN
            if (k == 2) chk("tbl_udf", 128'(o_udf), 128'(1));
`endif
        end
        // lane 3 overflow
        step(1, 0, 0, 0);
        for (int k = 0; k < 64; k++) step(0, 8'h08, rnd_row(), 0);
        chk("l3_full", 128'(o_full), 128'(1));
        chk("l3_ready", 128'(o_ready), 128'(0));
        step(0, 8'h08, rnd_row(), 0);
        chk("l3_full_drop", 128'(o_full), 128'(1));
`ifdef OFIFO_MULTI_ERR_EN
        chk("l3_ovf", 128'(o_ovf), 128'(1));
`endif
        for (int k = 0; k < 64; k++) step(0, 8'hF7, rnd_row(), 0);
        for (int k = 0; k < 64; k++) step(0, 0, 0, 1);
        chk("l3_drain_valid", 128'(o_valid), 128'(0));
        // almost-full threshold
        step(1, 0, 0, 0);
        for (int k = 0; k < 55; k++) step(0, 8'hFF, rnd_row(), 0);
        chk("af_55", 128'(o_afull), 128'(0));
        step(0, 8'hFF, rnd_row(), 0);
        chk("af_56", 128'(o_afull), 128'(1));
        step(0, 0, 0, 1);
        chk("af_rd", 128'(o_afull), 128'(0));
        // full with simultaneous write and read, then drain with wrap-around
        for (int k = 0; k < 9; k++) step(0, 8'hFF, rnd_row(), 0);
        chk("full_all", 128'(o_full), 128'(1));
        step(0, 8'hFF, rnd_row(), 1);
        chk("full_wr_rd", 128'(o_full), 128'(1));
        chk("full_wr_rd_vld", 128'(out_vld), 128'(1));
        for (int k = 0; k < 64; k++) step(0, 0, 0, 1);
        chk("drain_empty", 128'(o_valid), 128'(0));
        // random skewed traffic with a mid-stream reset
        step(1, 0, 0, 0);
        for (int k = 0; k < 200; k++) begin
            if (k == 100) begin
                step(1, 8'(($urandom)), rnd_row(), 1);
                chk("mid_rst_valid", 128'(o_valid), 128'(0));
                chk("mid_rst_vld", 128'(out_vld), 128'(0));
            end else begin
                step(0, 8'($urandom) | 8'($urandom), rnd_row(), ($urandom_range(0, 2) != 0));
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ofifo_multi.md
# ofifo_multi

Parametrised multi-column output FIFO collecting per-column PSUM results from the systolic array and releasing them row-wise to the SFU/output SRAM path. Each of `col` lanes is written independently; a row is read only when every lane holds data. It adds a configurable depth, a programmable almost-full threshold for array back-pressure, a registered read-data handshake, and per-lane occupancy accounting.

## Interface
- `col`, 8, number of lanes (array columns)
- `bw`, 16, data width per lane
- `depth`, 64, entries per lane; power of two, ≥ 4
- `af_lvl`, 56, almost-full threshold; 1 ≤ af_lvl ≤ depth
- `clk`  in  1  single clock, all logic rising-edge
- `reset`  in  1  synchronous, active-high
- `wr`  in  col  per-lane write strobe
- `in`  in  col*bw  lane i data at bits [(i+1)*bw-1 : i*bw]
- `rd`  in  1  row read request
- `out`  out  col*bw  registered row data, same lane packing
- `out_vld`  out  1  `out` holds a newly read row this cycle
- `o_valid`  out  1  every lane non-empty; a row is available
- `o_full`  out  1  any lane full
- `o_ready`  out  1  ~o_full
- `o_afull`  out  1  any lane occupancy ≥ af_lvl
- `o_ovf`, `o_udf`  out  1 each  sticky error flags (only with OFIFO_MULTI_ERR_EN)

## Operation
- Per lane: circular buffer, wr/rd pointers of log2(depth) bits wrapping modulo depth, occupancy counter log2(depth)+1 bits.
- Write: `wr[i]` at an edge stores `in` lane i at wr_ptr[i], increments ptr and count, when lane i is not full, or is full and a row read is accepted on the same edge (count unchanged).
- Write to a full lane without simultaneous accepted read: dropped, no state change; sets `o_ovf` if enabled.
- Row read accepted at an edge iff `rd` and `o_valid`; all lanes advance rd_ptr and decrement count together; `out` loads the head entries; `out_vld` = 1 for the following cycle.
- `rd` with `o_valid` = 0: ignored, `out` holds its previous value, `out_vld` = 0; sets `o_udf` if enabled.
- Lanes are never read individually; a lane that is ahead keeps its surplus.
- Same-edge write and read on a non-full lane: count unchanged, both pointers advance.
- Flags are combinational from the counters: empty[i] = (count==0), full[i] = (count==depth); `o_valid` = ~|empty, `o_full` = |full, `o_afull` = |(count ≥ af_lvl).

## Timing
- Reset: pointers and counts 0, `out` = 0, `out_vld` = 0, `o_valid` = 0, `o_full` = 0, `o_ready` = 1, `o_afull` = 0, `o_ovf`/`o_udf` = 0.
- Reset has priority over concurrent `wr`/`rd`; a mid-stream reset discards all contents in one cycle.
- Write-to-visible latency: a write at edge k makes the lane non-empty after edge k; `o_valid` can be 1 in cycle k+1.
- Read latency: `rd` sampled at edge k → `out`/`out_vld` valid in cycle k+1 (one cycle).
- Back-to-back reads are sustained at one row per cycle while `o_valid` stays 1.
- Flags reflect post-edge counts; no lookahead.

## Configuration
- `OFIFO_MULTI_ERR_EN` defined: `o_ovf` and `o_udf` ports present; each sets on a dropped write or ignored read and clears only on `reset`.
- Not defined: the ports and their logic are absent; drops and ignored reads are silent.

## Structure
- Shared package `ofifo_pkg`: pointer/count width functions (clog2-based), lane count type, default `depth`/`af_lvl` constants.
- One sub-module `ofifo_lane`: single-lane storage, pointers, counter, and empty/full/afull flags, with external `pop` input driven by the row-read accept. Top instantiates `col` lanes and owns the `out` register, `out_vld`, and the error flags.

## Test plan
- Reset, then write lane 0..6 once each (lane 7 idle), `rd`=1 → `o_valid`=0, `out_vld` stays 0, `o_udf`=1.
- Write all 8 lanes with value 16'h0A0i at lane i, `rd` next cycle → cycle after: `out_vld`=1, lane i reads 16'h0A0i, `o_valid`=0.
- Fill lane 3 with 64 writes → `o_full`=1, `o_ready`=0; 65th write dropped, `o_ovf`=1, count stays 64.
- With af_lvl=56: 55 writes to every lane → `o_afull`=0; 56th → `o_afull`=1; one read → 0.
- All lanes full, simultaneous `wr`=8'hFF and `rd` → write accepted, `o_full` remains 1, the 64-deep sequence is read back in order with wrap-around.
- Continuous writes and reads for 200 cycles with random lane skew → row order preserved, no data loss, `reset` mid-stream clears all flags next cycle.
